// File: rtl/interrupt_controller_pkg.sv
// rtl/interrupt_controller_pkg.sv - shared state encodings and default parameters for the interrupt controller
package interrupt_controller_pkg;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_FLUSH   = 3'd1,
    S_SAVE    = 3'd2,
    S_VECTOR  = 3'd3,
    S_SERVICE = 3'd4,
    S_RESTORE = 3'd5
  } state_t;

  localparam int         DEF_PC_W        = 8;
  localparam logic [7:0] DEF_VEC_ADDR    = 8'h01;
  localparam int         DEF_SYNC_STAGES = 2;

endpackage

// File: rtl/interrupt_controller_irq_sync.sv
// rtl/interrupt_controller_irq_sync.sv - irq synchroniser chain with registered rising-edge detect
module interrupt_controller_irq_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic irq,
  output logic rise
);

  logic [STAGES-1:0] sync_q;
  logic              prev_q;

  // rise is registered so the edge pulse comes straight from a flop into the pending logic
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
      prev_q <= 1'b0;
      rise   <= 1'b0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], irq};
      prev_q <= sync_q[STAGES-1];
      rise   <= sync_q[STAGES-1] & ~prev_q;
    end
  end

endmodule

// File: rtl/interrupt_controller.sv
// rtl/interrupt_controller.sv - interrupt entry/return sequencer: flush, save, vector, service, restore
module interrupt_controller
  import interrupt_controller_pkg::*;
#(
  parameter int              PC_W        = DEF_PC_W,
  parameter logic [PC_W-1:0] VEC_ADDR    = PC_W'(DEF_VEC_ADDR),
  parameter int              SYNC_STAGES = DEF_SYNC_STAGES
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            irq,
  input  logic            pipe_busy,
  input  logic            rti_exec,
  input  logic [PC_W-1:0] pc_ret,
  output logic            flush,
  output logic            intr,
  output logic            rti,
  output logic            stack_push,
  output logic [PC_W-1:0] stack_data,
  output logic            pc_load,
  output logic [PC_W-1:0] pc_load_addr,
  output logic            in_service
);

  state_t          state, state_nxt;
  logic            rise;
  logic            pending;
  logic [PC_W-1:0] ret_reg;

  interrupt_controller_irq_sync #(
    .STAGES(SYNC_STAGES)
  ) u_irq_sync (
    .clk (clk),
    .rst (rst),
    .irq (irq),
    .rise(rise)
  );

  // A fresh edge wins over the clear so an irq arriving during FLUSH is not lost
  always_ff @(posedge clk) begin
    if (rst) begin
      pending <= 1'b0;
    end else if (rise) begin
      pending <= 1'b1;
    end else if (state == S_FLUSH) begin
      pending <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ret_reg <= '0;
    end else if (state == S_FLUSH) begin
      ret_reg <= pc_ret;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:    if (pending && !pipe_busy) state_nxt = S_FLUSH;
      S_FLUSH:   state_nxt = S_SAVE;
      S_SAVE:    state_nxt = S_VECTOR;
      S_VECTOR:  state_nxt = S_SERVICE;
      S_SERVICE: if (rti_exec) state_nxt = S_RESTORE;
      S_RESTORE: state_nxt = S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    flush        = (state == S_FLUSH) || (state == S_SAVE);
    intr         = (state == S_SAVE);
    stack_push   = (state == S_SAVE);
    stack_data   = (state == S_SAVE) ? ret_reg : '0;
    pc_load      = (state == S_VECTOR);
    in_service   = (state == S_SERVICE);
    rti          = (state == S_RESTORE);
    pc_load_addr = VEC_ADDR;
  end

endmodule
